// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin two-port arbiter and access sequencer for a single-port memory
module mem_port_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_read_write,
    input  logic [DATA_W-1:0] mem_data_out
);
    localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3;
    logic [1:0] state;
    logic       ptr, win, we_l, sel;
    assign sel = (req0 && req1) ? ptr : req1;
    // mem_addr/mem_data_in double as the latched request; they hold through RESP and into IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            ptr            <= 1'b0;
            win            <= 1'b0;
            we_l           <= 1'b0;
            gnt0           <= 1'b0;
            gnt1           <= 1'b0;
            ack0           <= 1'b0;
            ack1           <= 1'b0;
            busy           <= 1'b0;
            rdata          <= '0;
            mem_addr       <= '0;
            mem_data_in    <= '0;
            mem_read_write <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req0 || req1) begin
                    state       <= SETUP;
                    win         <= sel;
                    we_l        <= sel ? we1 : we0;
                    mem_addr    <= sel ? addr1 : addr0;
                    mem_data_in <= sel ? wdata1 : wdata0;
                    gnt0        <= !sel;
                    gnt1        <= sel;
                    busy        <= 1'b1;
                end
                SETUP: begin
                    state          <= ACCESS;
                    mem_read_write <= we_l;
                end
                ACCESS: begin
                    state          <= RESP;
                    mem_read_write <= 1'b0;
                    ack0           <= !win;
                    ack1           <= win;
                    rdata          <= we_l ? rdata : mem_data_out;
                end
                default: begin
                    state <= IDLE;
                    ptr   <= !win;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized transactions checked against a transaction-level model
module tb_mem_port_arbiter;
    localparam int AW = 5;
    localparam int DW = 8;
    logic clk = 1'b0;
    logic reset, req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1, mem_addr;
    logic [DW-1:0] wdata0, wdata1, rdata, mem_data_in, mem_data_out;
    logic gnt0, gnt1, ack0, ack1, busy, mem_read_write;
    logic [DW-1:0] mem [2**AW] = '{default: '0};
    logic [DW-1:0] ref_mem [2**AW];
    logic [DW-1:0] ref_rdata;
    bit ptr;
    int vectors = 0;
    int miscompares = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .rdata(rdata), .busy(busy),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_read_write(mem_read_write), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (mem_read_write) mem[mem_addr] <= mem_data_in;
    assign mem_data_out = mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk(tag, {gnt0, gnt1, ack0, ack1, busy, mem_read_write}, 32'd0);
    endtask

    task automatic scramble;
        req0 = 1'($urandom); req1 = 1'($urandom);
        we0 = 1'($urandom); we1 = 1'($urandom);
        addr0 = AW'($urandom); addr1 = AW'($urandom);
        wdata0 = DW'($urandom); wdata1 = DW'($urandom);
    endtask

    // mode 0: inputs held; mode 1: inputs randomized mid-transaction;
    // mode 2: winner drops req in SETUP and the other port raises req in ACCESS
    task automatic txn(input bit r0, input bit r1, input bit w0, input bit w1,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1, input int mode);
        bit w, we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        req0 = r0; req1 = r1; we0 = w0; we1 = w1;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        if (!r0 && !r1) begin
            step;
            check_idle("noreq_idle");
            return;
        end
        w  = (r0 && r1) ? ptr : r1;
        we = w ? w1 : w0;
        a  = w ? a1 : a0;
        d  = w ? d1 : d0;
        step;
        chk("setup_ctl", {gnt0, gnt1, ack0, ack1, busy, mem_read_write}, {26'd0, !w, w, 2'b00, 1'b1, 1'b0});
        chk("setup_ad", {mem_addr, mem_data_in}, {a, d});
        if (mode == 1) scramble;
        if (mode == 2) begin if (w) req1 = 1'b0; else req0 = 1'b0; end
        step;
        chk("access_ctl", {gnt0, gnt1, ack0, ack1, busy, mem_read_write}, {26'd0, !w, w, 2'b00, 1'b1, we});
        chk("access_ad", {mem_addr, mem_data_in}, {a, d});
        if (mode == 1) scramble;
        if (mode == 2) begin if (w) req0 = 1'b1; else req1 = 1'b1; end
        step;
        if (we) ref_mem[a] = d;
        else ref_rdata = ref_mem[a];
        chk("resp_ctl", {gnt0, gnt1, ack0, ack1, busy, mem_read_write}, {26'd0, !w, w, !w, w, 1'b1, 1'b0});
        chk("resp_ad", {mem_addr, mem_data_in}, {a, d});
        chk("resp_rdata", rdata, ref_rdata);
        if (mode == 1) scramble;
        step;
        ptr = !w;
        check_idle("post_idle");
        chk("post_rdata", rdata, ref_rdata);
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;
        ref_rdata = '0;
        ptr = 1'b0;
        reset = 1'b1;
        {req0, we0, req1, we1} = '0;
        {addr0, addr1, wdata0, wdata1} = '0;
        step;
        step;
        reset = 1'b0;
        chk("reset_state", {gnt0, gnt1, ack0, ack1, busy, mem_read_write, mem_addr, mem_data_in, rdata}, 32'd0);

        txn(0, 1, 0, 1, 0, 10, 0, 8'h06, 0);
        txn(1, 0, 0, 0, 10, 0, 0, 0, 0);

        txn(1, 0, 1, 0, 3, 0, 8'h33, 0, 0);
        txn(0, 1, 0, 1, 0, 4, 0, 8'h44, 0);
        for (int i = 0; i < 4; i++) txn(1, 1, 0, 0, 3, 4, 0, 0, 0);

        txn(0, 1, 0, 0, 0, 10, 0, 0, 2);
        txn(1, 0, 0, 0, 4, 0, 0, 0, 0);

        txn(1, 0, 1, 0, 5, 0, 8'hAA, 0, 0);
        req0 = 1'b0; req1 = 1'b1; we1 = 1'b1; addr1 = 5; wdata1 = 8'h55;
        step;
        chk("abort_setup", {gnt0, gnt1, busy}, 32'b011);
        reset = 1'b1;
        req1 = 1'b0;
        step;
        reset = 1'b0;
        ptr = 1'b0;
        ref_rdata = '0;
        chk("abort_reset", {gnt0, gnt1, ack0, ack1, busy, mem_read_write, mem_addr, mem_data_in, rdata}, 32'd0);
        step;
        check_idle("abort_no_ack");
        txn(1, 1, 0, 0, 5, 5, 0, 0, 0);

        req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step;
            check_idle("quiet_idle");
        end

        for (int i = 0; i < 60; i++)
            txn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                AW'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
                int'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
